// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_pkg : opcodes, FSM encoding and status bit positions       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_slave_pkg;

  localparam logic [7:0] SPI_OP_WR  = 8'h02;
  localparam logic [7:0] SPI_OP_RD  = 8'h0B;
  localparam logic [7:0] SPI_OP_QWR = 8'h38;
  localparam logic [7:0] SPI_OP_QRD = 8'hEB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } spi_state_e;

  localparam int STAT_OVERFLOW = 0;
  localparam int STAT_UNDERRUN = 1;
  localparam int STAT_ILLEGAL  = 2;

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_sync : pin synchronizers with sclk and csn edge detection  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sclk,
  input  logic       spi_csn,
  input  logic [3:0] spi_sdi,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       csn_fall,
  output logic       csn_s,
  output logic [3:0] sdi_s
);

  logic [SYNC_STAGES-1:0]      r_sclk_q;
  logic [SYNC_STAGES-1:0]      r_csn_q;
  logic [SYNC_STAGES-1:0][3:0] r_sdi_q;
  logic                        r_sclk_d;
  logic                        r_csn_d;

  // csn resets low so a reset mid-frame cannot fake a new falling edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_q <= '0;
      r_csn_q  <= '0;
      r_sdi_q  <= '0;
      r_sclk_d <= 1'b0;
      r_csn_d  <= 1'b0;
    end else begin
      r_sclk_q <= {r_sclk_q[SYNC_STAGES-2:0], spi_sclk};
      r_csn_q  <= {r_csn_q[SYNC_STAGES-2:0], spi_csn};
      r_sdi_q  <= {r_sdi_q[SYNC_STAGES-2:0], spi_sdi};
      r_sclk_d <= r_sclk_q[SYNC_STAGES-1];
      r_csn_d  <= r_csn_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = r_sclk_q[SYNC_STAGES-1] & ~r_sclk_d;
  assign sclk_fall = ~r_sclk_q[SYNC_STAGES-1] & r_sclk_d;
  assign csn_fall  = ~r_csn_q[SYNC_STAGES-1] & r_csn_d;
  assign csn_s     = r_csn_q[SYNC_STAGES-1];
  assign sdi_s     = r_sdi_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_controller : std/quad SPI target, cmd/addr/dummy/data      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_slave_controller
  import spi_slave_pkg::*;
#(
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_sclk,
  input  logic        spi_csn,
  input  logic [3:0]  spi_sdi,
  output logic [3:0]  spi_sdo,
  output logic [3:0]  spi_oe,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] rd_addr,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  input  logic        rd_valid,
  output logic        eot,
  output logic [2:0]  status,
  input  logic        status_clr
);

  logic       w_rise, w_fall, w_csn_fall, w_csn;
  logic [3:0] w_sdi;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .spi_sclk  (spi_sclk),
    .spi_csn   (spi_csn),
    .spi_sdi   (spi_sdi),
    .sclk_rise (w_rise),
    .sclk_fall (w_fall),
    .csn_fall  (w_csn_fall),
    .csn_s     (w_csn),
    .sdi_s     (w_sdi)
  );

  spi_state_e  r_state, w_state_nxt;
  logic [5:0]  r_bit_cnt, w_step, w_cnt_nxt;
  logic [7:0]  r_dummy_cnt;
  logic        r_quad, r_read;
  logic [31:0] r_sh_in, w_sh_nxt;
  logic [31:0] r_sdo_sh, r_hold, r_waddr, r_rd_addr, r_wr_addr, r_wr_data;
  logic        r_hold_vld, r_wr_valid, r_rd_req, r_eot;
  logic [2:0]  r_status, w_evt;
  logic        w_abort, w_bit_en, w_cmd_done, w_addr_done, w_word_done, w_load, w_shout;
  logic        w_op_ok, w_op_quad, w_op_read;

  assign w_step    = r_quad ? 6'd4 : 6'd1;
  assign w_cnt_nxt = r_bit_cnt + w_step;
  assign w_sh_nxt  = r_quad ? {r_sh_in[27:0], w_sdi} : {r_sh_in[30:0], w_sdi[0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_bit_en    = 1'b0;
    w_cmd_done  = 1'b0;
    w_addr_done = 1'b0;
    w_word_done = 1'b0;
    w_load      = 1'b0;
    w_shout     = 1'b0;
    w_op_ok     = 1'b0;
    w_op_quad   = 1'b0;
    w_op_read   = 1'b0;
    if (r_state != ST_IDLE && w_csn) begin
      w_abort     = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_csn_fall) w_state_nxt = ST_CMD;
        ST_CMD: begin
          w_bit_en = w_rise;
          if (w_rise && w_cnt_nxt == 6'd8) begin
            w_cmd_done = 1'b1;
            case (w_sh_nxt[7:0])
              SPI_OP_WR:  w_op_ok = 1'b1;
              SPI_OP_RD:  begin w_op_ok = 1'b1; w_op_read = 1'b1; end
              SPI_OP_QWR: begin w_op_ok = 1'b1; w_op_quad = 1'b1; end
              SPI_OP_QRD: begin w_op_ok = 1'b1; w_op_quad = 1'b1; w_op_read = 1'b1; end
              default:    w_op_ok = 1'b0;
            endcase
            w_state_nxt = w_op_ok ? ST_ADDR : ST_IGNORE;
          end
        end
        ST_ADDR: begin
          w_bit_en = w_rise;
          if (w_rise && w_cnt_nxt == 6'd32) begin
            w_addr_done = 1'b1;
            w_state_nxt = r_read ? ST_DUMMY : ST_WDATA;
          end
        end
        ST_DUMMY:
          if (w_rise && r_dummy_cnt == 8'(DUMMY_CYCLES - 1)) w_state_nxt = ST_RDATA;
        ST_WDATA: begin
          w_bit_en    = w_rise;
          w_word_done = w_rise && (w_cnt_nxt == 6'd32);
        end
        ST_RDATA: begin
          w_bit_en = w_rise;
          // bit count zero on a fall means the master has consumed a whole word
          w_load   = w_fall && (r_bit_cnt == 6'd0);
          w_shout  = w_fall && (r_bit_cnt != 6'd0);
        end
        ST_IGNORE: w_state_nxt = ST_IGNORE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_evt                = 3'b000;
    w_evt[STAT_OVERFLOW] = w_word_done & r_wr_valid & ~wr_ready;
    w_evt[STAT_UNDERRUN] = w_load & ~rd_valid & ~r_hold_vld;
    w_evt[STAT_ILLEGAL]  = w_cmd_done & ~w_op_ok;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt   <= 6'd0;
      r_dummy_cnt <= 8'd0;
      r_quad      <= 1'b0;
      r_read      <= 1'b0;
      r_sh_in     <= 32'd0;
      r_sdo_sh    <= 32'd0;
      r_hold      <= 32'd0;
      r_hold_vld  <= 1'b0;
      r_waddr     <= 32'd0;
      r_rd_addr   <= 32'd0;
      r_wr_addr   <= 32'd0;
      r_wr_data   <= 32'd0;
      r_wr_valid  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_eot       <= 1'b0;
      r_status    <= 3'b000;
    end else begin
      r_rd_req <= 1'b0;
      r_eot    <= w_abort;
      r_status <= (status_clr ? 3'b000 : r_status) | w_evt;
      if (r_wr_valid && wr_ready) r_wr_valid <= 1'b0;
      if (rd_valid) begin
        r_hold     <= rd_data;
        r_hold_vld <= 1'b1;
      end
      if (w_abort) begin
        r_bit_cnt  <= 6'd0;
        r_hold_vld <= 1'b0;
      end
      if (r_state == ST_IDLE && w_csn_fall) begin
        r_bit_cnt <= 6'd0;
        r_quad    <= 1'b0;
        r_read    <= 1'b0;
      end
      if (w_bit_en) begin
        r_sh_in   <= w_sh_nxt;
        r_bit_cnt <= (w_cmd_done || w_cnt_nxt == 6'd32) ? 6'd0 : w_cnt_nxt;
      end
      if (w_cmd_done) begin
        r_quad <= w_op_quad;
        r_read <= w_op_read;
      end
      if (w_addr_done) begin
        r_waddr     <= w_sh_nxt;
        r_rd_addr   <= w_sh_nxt;
        r_dummy_cnt <= 8'd0;
        r_sdo_sh    <= 32'd0;
        if (r_read) begin
          r_rd_req   <= 1'b1;
          r_hold_vld <= 1'b0;
        end
      end
      if (r_state == ST_DUMMY && w_rise && !w_abort) r_dummy_cnt <= r_dummy_cnt + 8'd1;
      if (w_word_done) begin
        r_wr_data  <= w_sh_nxt;
        r_wr_addr  <= r_waddr;
        r_waddr    <= r_waddr + 32'd4;
        r_wr_valid <= 1'b1;
      end
      if (w_load) begin
        r_sdo_sh   <= rd_valid ? rd_data : (r_hold_vld ? r_hold : 32'd0);
        r_rd_addr  <= r_rd_addr + 32'd4;
        r_rd_req   <= 1'b1;
        r_hold_vld <= 1'b0;
      end else if (w_shout) begin
        r_sdo_sh <= r_quad ? {r_sdo_sh[27:0], 4'h0} : {r_sdo_sh[30:0], 1'b0};
      end
    end
  end

  assign spi_oe   = (r_state == ST_RDATA) ? (r_quad ? 4'b1111 : 4'b0010) : 4'b0000;
  assign spi_sdo  = spi_oe & (r_quad ? r_sdo_sh[31:28] : {2'b00, r_sdo_sh[31], 1'b0});
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_valid = r_wr_valid;
  assign rd_addr  = r_rd_addr;
  assign rd_req   = r_rd_req;
  assign eot      = r_eot;
  assign status   = r_status;

endmodule
`default_nettype wire
